// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: states, mux selects,
// ALU operation codes, opcode/funct values and the instruction decode helpers.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TRAP_IRQ = 2'd0,
        TRAP_EXC = 2'd1,
        TRAP_BUS = 2'd2
    } trap_t;

    localparam logic [2:0] PCSRC_PC4    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_JR     = 3'd3;
    localparam logic [2:0] PCSRC_IRQ    = 3'd4;
    localparam logic [2:0] PCSRC_EXC    = 3'd5;
    localparam logic [2:0] PCSRC_BUSERR = 3'd6;

    localparam logic [1:0] REGDST_RD = 2'd0;
    localparam logic [1:0] REGDST_RT = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;
    localparam logic [1:0] REGDST_K0 = 2'd3;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;
    localparam logic [1:0] MEMTOREG_LUI = 2'd3;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NE  = 6'b110001;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_GTZ = 6'b111111;
    localparam logic [5:0] ALU_LTZ = 6'b111011;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [5:0] fun;
        logic       src1;
        logic       src2;
        logic       ext;
    } alu_ctl_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE)
            return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR, [FN_ADD:FN_NOR], FN_SLT};
        return op inside {[OP_REGIMM:OP_ANDI], OP_LUI, OP_LW, OP_SW};
    endfunction

    // Shifts take shamt on operand 1; immediates on operand 2, sign-extended except andi/lui.
    function automatic alu_ctl_t decode_alu(input logic [5:0] op, input logic [5:0] fn);
        alu_ctl_t c;
        c.fun  = ALU_ADD;
        c.src1 = 1'b0;
        c.src2 = 1'b0;
        c.ext  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL:          begin c.fun = ALU_SLL; c.src1 = 1'b1; end
                    FN_SRL:          begin c.fun = ALU_SRL; c.src1 = 1'b1; end
                    FN_SRA:          begin c.fun = ALU_SRA; c.src1 = 1'b1; end
                    FN_SUB, FN_SUBU: c.fun = ALU_SUB;
                    FN_AND:          c.fun = ALU_AND;
                    FN_OR:           c.fun = ALU_OR;
                    FN_XOR:          c.fun = ALU_XOR;
                    FN_NOR:          c.fun = ALU_NOR;
                    FN_SLT:          c.fun = ALU_LT;
                    default:         c.fun = ALU_ADD;
                endcase
            end
            OP_REGIMM: begin c.fun = ALU_LTZ; c.ext = 1'b1; end
            OP_BEQ:    begin c.fun = ALU_EQ;  c.ext = 1'b1; end
            OP_BNE:    begin c.fun = ALU_NE;  c.ext = 1'b1; end
            OP_BLEZ:   begin c.fun = ALU_LEZ; c.ext = 1'b1; end
            OP_BGTZ:   begin c.fun = ALU_GTZ; c.ext = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin c.src2 = 1'b1; c.ext = 1'b1; end
            OP_SLTI, OP_SLTIU: begin c.fun = ALU_LT; c.src2 = 1'b1; c.ext = 1'b1; end
            OP_ANDI:   begin c.fun = ALU_AND; c.src2 = 1'b1; end
            OP_LUI:    c.src2 = 1'b1;
            default:   c.fun = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational masked priority encoder: the lowest-numbered pending line wins.
module irq_prio_arb #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               block,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [NUM_IRQ-1:0] pend;

    assign pend = req & mask & {NUM_IRQ{~block}};

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS32 control FSM with masked IRQ entry and a memory-ready handshake.
// Define MC_MEM_TIMEOUT_EN to add a mem_ready watchdog that traps to the bus-error vector.
module mc_control
    import mc_pkg::*;
#(
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic                ker,
    input  logic                mem_ready,
    output logic [2:0]          state,
    output logic                pc_wr,
    output logic                ir_wr,
    output logic                reg_wr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [2:0]          pc_src,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [5:0]          alu_fun,
    output logic                alu_src1,
    output logic                alu_src2,
    output logic                ext_op,
    output logic                irq_take,
    output logic [IRQ_ID_W-1:0] irq_id
);

    state_t                state_q, state_n;
    trap_t                 trap_q, trap_n;
    logic [5:0]            op_q, fn_q;
    logic                  fetch_wait_q;
    logic [IRQ_ID_W-1:0]   irq_id_q;
    logic                  irq_valid, irq_enter;
    logic [IRQ_ID_W-1:0]   arb_id;
    logic                  timeout;
    alu_ctl_t              actl;

    irq_prio_arb #(.NUM_IRQ(NUM_IRQ), .ID_W(IRQ_ID_W)) u_arb (
        .req   (irq),
        .mask  (irq_mask),
        .block (ker),
        .valid (irq_valid),
        .id    (arb_id)
    );

`ifdef MC_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] stall_q;

    assign timeout = (stall_q == TO_W'(TIMEOUT_CYCLES));

    // Counts consecutive stalled cycles within one FETCH or MEM visit.
    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && state_n == state_q)
            stall_q <= stall_q + 1'b1;
        else
            stall_q <= '0;
    end
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign actl   = decode_alu(op_q, fn_q);
    assign state  = state_q;
    assign irq_id = irq_id_q;

    // Decode fields are captured at DECODE so they stay fixed until the instruction retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            trap_q       <= TRAP_IRQ;
            op_q         <= '0;
            fn_q         <= '0;
            fetch_wait_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            state_q      <= state_n;
            fetch_wait_q <= (state_q == S_FETCH) && (state_n == S_FETCH);
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state_n == S_TRAP)
                trap_q <= trap_n;
            if (irq_enter)
                irq_id_q <= arb_id;
        end
    end

    always_comb begin
        state_n    = state_q;
        trap_n     = TRAP_IRQ;
        irq_enter  = 1'b0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_src     = PCSRC_PC4;
        reg_dst    = REGDST_RD;
        mem_to_reg = MEMTOREG_ALU;
        alu_fun    = ALU_ADD;
        alu_src1   = 1'b0;
        alu_src2   = 1'b0;
        ext_op     = 1'b0;
        irq_take   = 1'b0;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_fun  = actl.fun;
            alu_src1 = actl.src1;
            alu_src2 = actl.src2;
            ext_op   = actl.ext;
        end
        case (state_q)
            // Interrupts are only looked at on the first FETCH cycle, never mid-read.
            S_FETCH: begin
                if (!fetch_wait_q && irq_valid) begin
                    irq_enter = 1'b1;
                    trap_n    = TRAP_IRQ;
                    state_n   = S_TRAP;
                end else if (timeout) begin
                    trap_n  = TRAP_BUS;
                    state_n = S_TRAP;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_wr   = 1'b1;
                        pc_wr   = 1'b1;
                        state_n = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (is_legal(opcode, funct)) begin
                    state_n = S_EXEC;
                end else begin
                    trap_n  = TRAP_EXC;
                    state_n = S_TRAP;
                end
            end
            S_EXEC: begin
                if (op_q == OP_REGIMM || (op_q >= OP_BEQ && op_q <= OP_BGTZ)) begin
                    pc_wr   = 1'b1;
                    pc_src  = PCSRC_BRANCH;
                    state_n = S_FETCH;
                end else if (op_q == OP_J || op_q == OP_JAL) begin
                    pc_wr      = 1'b1;
                    pc_src     = PCSRC_JUMP;
                    reg_wr     = (op_q == OP_JAL);
                    reg_dst    = REGDST_RA;
                    mem_to_reg = MEMTOREG_PC;
                    state_n    = S_FETCH;
                end else if (op_q == OP_RTYPE && (fn_q == FN_JR || fn_q == FN_JALR)) begin
                    pc_wr      = 1'b1;
                    pc_src     = PCSRC_JR;
                    reg_wr     = (fn_q == FN_JALR);
                    reg_dst    = REGDST_RD;
                    mem_to_reg = MEMTOREG_PC;
                    state_n    = S_FETCH;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    trap_n  = TRAP_BUS;
                    state_n = S_TRAP;
                end else begin
                    mem_rd = (op_q == OP_LW);
                    mem_wr = (op_q != OP_LW);
                    if (mem_ready)
                        state_n = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (op_q == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                mem_to_reg = (op_q == OP_LW)  ? MEMTOREG_MEM :
                             (op_q == OP_LUI) ? MEMTOREG_LUI : MEMTOREG_ALU;
                state_n    = S_FETCH;
            end
            S_TRAP: begin
                pc_wr      = 1'b1;
                reg_wr     = 1'b1;
                reg_dst    = REGDST_K0;
                mem_to_reg = MEMTOREG_PC;
                case (trap_q)
                    TRAP_IRQ: begin pc_src = PCSRC_IRQ; irq_take = 1'b1; end
                    TRAP_EXC: pc_src = PCSRC_EXC;
                    default:  pc_src = PCSRC_BUSERR;
                endcase
                state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
        // A reset cycle must never let a half-finished instruction write anything.
        if (reset) begin
            pc_wr      = 1'b0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            pc_src     = PCSRC_PC4;
            reg_dst    = REGDST_RD;
            mem_to_reg = MEMTOREG_ALU;
            alu_fun    = ALU_ADD;
            alu_src1   = 1'b0;
            alu_src2   = 1'b0;
            ext_op     = 1'b0;
            irq_take   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a driver plays per-cycle directed vectors and queues
// the hand-computed outputs; a monitor compares them mid-cycle.
module tb_mc_control;

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] FETCH = 5'b11010;
    localparam logic [4:0] RD    = 5'b00010;
    localparam logic [4:0] WR    = 5'b00001;
    localparam logic [4:0] REG   = 5'b00100;
    localparam logic [4:0] PC    = 5'b10000;
    localparam logic [4:0] PCREG = 5'b10100;

    localparam logic [5:0] A_ADD = 6'b000000;
    localparam logic [5:0] A_SUB = 6'b000001;
    localparam logic [5:0] A_SLL = 6'b100000;
    localparam logic [5:0] A_EQ  = 6'b110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] opcode, funct;
    logic [3:0] irq, irq_mask;
    logic       ker, mem_ready;
    logic [2:0] state, pc_src;
    logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr;
    logic [1:0] reg_dst, mem_to_reg, irq_id;
    logic [5:0] alu_fun;
    logic       alu_src1, alu_src2, ext_op, irq_take;

    mc_control #(.NUM_IRQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .irq        (irq),
        .irq_mask   (irq_mask),
        .ker        (ker),
        .mem_ready  (mem_ready),
        .state      (state),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_fun    (alu_fun),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .ext_op     (ext_op),
        .irq_take   (irq_take),
        .irq_id     (irq_id)
    );

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] irq;
        logic [3:0] mask;
        logic       ker;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [26:0] val;
        logic [26:0] care;
        int          tag;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    string names[$];
    stim_t cur;
    logic [1:0] exp_id;
    int    checks = 0;
    int    errors = 0;
    bit    drv_done = 1'b0;

    function automatic logic [26:0] observe();
        return {state, pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, pc_src, reg_dst, mem_to_reg,
                alu_fun, alu_src1, alu_src2, ext_op, irq_take, irq_id};
    endfunction

    task automatic si(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic [3:0] rq, input logic [3:0] msk, input logic k, input logic rdy);
        cur = '{rst: rst, op: op, fn: fn, irq: rq, mask: msk, ker: k, rdy: rdy};
    endtask

    // mode 0: auto care, 1: every field, 2: strobes and irq_take only, 3: auto minus ALU fields
    task automatic ex(input string name, input logic [2:0] st, input logic [4:0] stb,
                      input logic [2:0] pcs, input logic [1:0] rd, input logic [1:0] mtr,
                      input logic [5:0] af, input logic [2:0] srcs, input logic take, input int mode);
        exp_t e;
        e.val  = {st, stb, pcs, rd, mtr, af, srcs, take, exp_id};
        e.care = '0;
        if (mode == 1) begin
            e.care = '1;
        end else begin
            e.care[23:19] = 5'b11111;
            e.care[2]     = 1'b1;
            if (mode != 2) begin
                e.care[26:24] = 3'b111;
                e.care[1:0]   = 2'b11;
                if (stb[4]) e.care[18:16] = 3'b111;
                if (stb[2]) e.care[15:12] = 4'b1111;
                if (st == 3'd2 && mode == 0) e.care[11:3] = 9'h1FF;
            end
        end
        names.push_back(name);
        e.tag = names.size() - 1;
        vecs.push_back('{s: cur, e: e});
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.s.rst;
        opcode    = v.s.op;
        funct     = v.s.fn;
        irq       = v.s.irq;
        irq_mask  = v.s.mask;
        ker       = v.s.ker;
        mem_ready = v.s.rdy;
        sb.push_back(v.e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [26:0] act;
        act = observe();
        checks++;
        if (((act ^ e.val) & e.care) !== 27'd0) begin
            errors++;
            $display("[TB] FAIL %s: got %07h expected %07h (care %07h)",
                     names[e.tag], act, e.val, e.care);
        end
    endtask

    task automatic build();
        exp_id = 2'd0;
        si(1, 6'h00, 6'h20, 4'h0, 4'hF, 0, 1);
        ex("reset", 0, NONE, 0, 0, 0, A_ADD, 3'b000, 0, 1);
        // add
        si(0, 6'h00, 6'h20, 4'h0, 4'hF, 0, 1);
        ex("add fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("add decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("add exec",   2, NONE,  0, 0, 0, A_ADD, 3'b000, 0, 0);
        ex("add wb",     4, REG,   0, 0, 0, 0, 0, 0, 0);
        // lw with three stall cycles in MEM
        si(0, 6'h23, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("lw fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("lw decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("lw exec",   2, NONE,  0, 0, 0, A_ADD, 3'b011, 0, 0);
        si(0, 6'h23, 6'h00, 4'h0, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) ex("lw mem wait", 3, RD, 0, 0, 0, 0, 0, 0, 0);
        si(0, 6'h23, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("lw mem done", 3, RD,  0, 0, 0, 0, 0, 0, 0);
        ex("lw wb",       4, REG, 0, 1, 1, 0, 0, 0, 0);
        // interrupt at FETCH entry: lines 1 and 2 pending, line 1 wins
        si(0, 6'h00, 6'h20, 4'b0110, 4'hF, 0, 1);
        ex("irq fetch", 0, NONE, 0, 0, 0, 0, 0, 0, 0);
        exp_id = 2'd1;
        ex("irq trap", 5, PCREG, 4, 3, 2, 0, 0, 1, 0);
        // kernel mode blocks the same request
        si(0, 6'h00, 6'h22, 4'b0110, 4'hF, 1, 1);
        ex("ker fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("sub decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("sub exec",   2, NONE,  0, 0, 0, A_SUB, 3'b000, 0, 0);
        ex("sub wb",     4, REG,   0, 0, 0, 0, 0, 0, 0);
        // illegal opcode with a masked-off request
        si(0, 6'h3F, 6'h00, 4'b1000, 4'b0111, 0, 1);
        ex("masked fetch", 0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("ill decode",   1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("ill trap",     5, PCREG, 5, 3, 2, 0, 0, 0, 0);
        // beq
        si(0, 6'h04, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("beq fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("beq decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("beq exec",   2, PC,    1, 0, 0, A_EQ, 3'b001, 0, 0);
        // jal; a request raised mid-instruction waits for the next FETCH
        si(0, 6'h03, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("jal fetch", 0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        si(0, 6'h03, 6'h00, 4'b1010, 4'b1101, 0, 1);
        ex("jal decode",    1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("jal exec",      2, PCREG, 2, 2, 2, 0, 0, 0, 3);
        ex("late irq fetch", 0, NONE, 0, 0, 0, 0, 0, 0, 0);
        exp_id = 2'd3;
        ex("late irq trap", 5, PCREG, 4, 3, 2, 0, 0, 1, 0);
        // sw aborted by reset during MEM
        si(0, 6'h2B, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("sw fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("sw decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("sw exec",   2, NONE,  0, 0, 0, A_ADD, 3'b011, 0, 0);
        si(0, 6'h2B, 6'h00, 4'h0, 4'hF, 0, 0);
        ex("sw mem", 3, WR, 0, 0, 0, 0, 0, 0, 0);
        si(1, 6'h2B, 6'h00, 4'h0, 4'hF, 0, 0);
        ex("sw reset", 3, NONE, 0, 0, 0, 0, 0, 0, 2);
        exp_id = 2'd0;
        // jalr after reset, first fetch stalled once
        si(0, 6'h00, 6'h09, 4'h0, 4'hF, 0, 0);
        ex("post reset fetch", 0, RD, 0, 0, 0, 0, 0, 0, 0);
        si(0, 6'h00, 6'h09, 4'h0, 4'hF, 0, 1);
        ex("jalr fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("jalr decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("jalr exec",   2, PCREG, 3, 0, 2, 0, 0, 0, 3);
        // lui
        si(0, 6'h0F, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("lui fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("lui decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("lui exec",   2, NONE,  0, 0, 0, A_ADD, 3'b010, 0, 0);
        ex("lui wb",     4, REG,   0, 1, 3, 0, 0, 0, 0);
        // sll
        si(0, 6'h00, 6'h00, 4'h0, 4'hF, 0, 1);
        ex("sll fetch",  0, FETCH, 0, 0, 0, 0, 0, 0, 0);
        ex("sll decode", 1, NONE,  0, 0, 0, 0, 0, 0, 0);
        ex("sll exec",   2, NONE,  0, 0, 0, A_SLL, 3'b100, 0, 0);
        ex("sll wb",     4, REG,   0, 0, 0, 0, 0, 0, 0);
        si(0, 6'h00, 6'h20, 4'h0, 4'hF, 0, 0);
        ex("final fetch wait", 0, RD, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : driver
        reset     = 1'b1;
        opcode    = '0;
        funct     = '0;
        irq       = '0;
        irq_mask  = '0;
        ker       = 1'b0;
        mem_ready = 1'b0;
        build();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
        end
        @(posedge clk);
        #1;
        drv_done = 1'b1;
    end

    initial begin : monitor
        for (int cyc = 0; cyc < 2000 && !drv_done; cyc++) begin
            @(negedge clk);
            while (sb.size() > 0) checkOutput(sb.pop_front());
        end
        if (!drv_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL watchdog: driver done=%0d required 1", drv_done);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS32 control unit.
- FSM sequences FETCH/DECODE/EXEC/MEM/WB/TRAP and emits per-state datapath strobes.
- Adds parametrised multi-channel masked IRQ arbitration and a memory-ready handshake.
- Sits between instruction register/memory interface and the shared-ALU datapath.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines; index 0 is highest priority.
- IRQ_ID_W, $clog2(NUM_IRQ) (min 1), width of irq_id.
- TIMEOUT_CYCLES, 16, mem_ready watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction opcode, valid from DECODE onward (IR output).
- funct  in  6  R-type function field.
- irq  in  NUM_IRQ  level interrupt requests.
- irq_mask  in  NUM_IRQ  1 = line enabled.
- ker  in  1  kernel mode (PC[31]); blocks interrupts.
- mem_ready  in  1  memory access completes this cycle.
- state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5.
- pc_wr  out  1  PC write strobe.
- ir_wr  out  1  instruction register load.
- reg_wr  out  1  register file write.
- mem_rd / mem_wr  out  1 each  memory strobes.
- pc_src  out  3  0 PC+4, 1 branch, 2 jump, 3 jr, 4 interrupt vector, 5 exception vector, 6 bus-error vector.
- reg_dst  out  2  0 rd, 1 rt, 2 $ra, 3 $k0.
- mem_to_reg  out  2  0 ALU, 1 mem, 2 return PC, 3 LUI.
- alu_fun  out  6  ALU op code.
- alu_src1 / alu_src2 / ext_op  out  1 each  operand selects / sign-extend.
- irq_take  out  1  one-cycle pulse on interrupt entry.
- irq_id  out  IRQ_ID_W  winning line, registered at FETCH, held until next take.

Behaviour:
- Reset: state=FETCH; all strobes, irq_take, irq_id=0; pc_src, reg_dst, mem_to_reg, alu_fun = 0. Reset in any state aborts the instruction with no write strobe.
- Strobes (pc_wr, ir_wr, reg_wr, mem_rd, mem_wr) are Moore/decoded from registered state plus opcode. Registered decode fields are stable from DECODE to instruction end.
- FETCH, entry check: pend = irq & irq_mask & {NUM_IRQ{~ker}}.
  - pend != 0: latch irq_id = lowest set index, go to TRAP (fetch skipped).
  - Otherwise assert mem_rd. Hold while mem_ready=0.
  - On mem_ready: ir_wr=1, pc_wr=1, pc_src=0, go to DECODE.
- DECODE: legal set is opcode 01-0C, 0F, 23, 2B; opcode 00 with funct 00, 02, 03, 08, 09, 20-27, 2A.
  - Illegal: TRAP, exception flavour (pc_src=5).
  - Legal: EXEC.
- EXEC: drive alu_fun and alu_src per instruction; ALU codes as in the shared package.
  - Branch (01, 04-07): pc_wr=1, pc_src=1; datapath gates with ALU result. Go to FETCH.
  - j: pc_wr, pc_src=2. jal: additionally reg_wr, reg_dst=2, mem_to_reg=2. Go to FETCH.
  - jr: pc_wr, pc_src=3. jalr: additionally reg_wr, reg_dst=0, mem_to_reg=2. Go to FETCH.
  - lw/sw: MEM. All others: WB.
- MEM: lw asserts mem_rd, sw asserts mem_wr; both held until mem_ready.
  - lw completes to WB; sw completes to FETCH.
- WB: reg_wr=1, one cycle. reg_dst=0 for opcode 00, else 1. mem_to_reg=1 for lw, 3 for lui, else 0. Go to FETCH.
- TRAP: one cycle. pc_wr=1; pc_src=4 (irq), 5 (illegal) or 6 (timeout). reg_wr=1, reg_dst=3, mem_to_reg=2. irq_take=1 only for irq. Go to FETCH.
- Interrupts are sampled only at FETCH entry; mid-instruction IRQs wait. Simultaneous IRQ and illegal instruction: IRQ wins, since it is checked before fetch.
- Latency with mem_ready=1: R-type/I-ALU 4 cycles, lw 5, sw 4, branch/jump 3, trap 1.

Optional Feature:
- MC_MEM_TIMEOUT_EN defined: counter of consecutive mem_ready=0 cycles in FETCH or MEM, cleared on state change. Reaching TIMEOUT_CYCLES goes to TRAP with pc_src=6, mem strobes dropped.
- Undefined: waits indefinitely; pc_src=6 never produced.

Decomposition:
- Package mc_pkg: state encodings, PCSRC_*/REGDST_*/MEMTOREG_* constants, ALU_ADD=000000, ALU_SUB=000001, ALU_AND=011000, ALU_OR=011110, ALU_XOR=010110, ALU_NOR=010001, ALU_SLL=100000, ALU_SRL=100001, ALU_SRA=100011, ALU_LT=110101, ALU_EQ=110011, ALU_NE=110001, ALU_LEZ=111101, ALU_GTZ=111111, ALU_LTZ=111011.
- Sub-module irq_prio_arb (NUM_IRQ): combinational masked priority encoder producing valid and id.

Test Plan:
- add (op 00, fn 20), mem_ready=1 -> states 0,1,2,4,0; reg_wr=1 only in WB, reg_dst=0, alu_fun=000000.
- lw, mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles, then WB with mem_to_reg=1; 8 cycles total.
- irq=4'b0110, mask=4'b1111, ker=0 at FETCH -> TRAP, irq_id=1, irq_take pulse, pc_src=4, reg_dst=3; with ker=1 -> normal fetch.
- opcode 3F -> FETCH, DECODE, TRAP with pc_src=5, irq_take=0.
- reset asserted during MEM of sw -> next cycle state=0, mem_wr=0, no reg_wr.
- MC_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready stuck 0 in FETCH -> TRAP pc_src=6 after 16 cycles.
